// File: rtl/lm_sm_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lm_sm_sequencer_pkg
//  Description : Shared constants and types for the LM/SM micro-op sequencer.
//                Holds the LM/SM opcode values, the register-mask and
//                register-index widths, and the sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package lm_sm_sequencer_pkg;

  // One mask bit per architectural register R0..R7.
  localparam int MASKW = 8;
  // Width of an architectural register index.
  localparam int REGW  = 3;

  // Major opcodes of the load/store-multiple instructions.
  localparam logic [3:0] OPC_LM = 4'b0110;
  localparam logic [3:0] OPC_SM = 4'b0111;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

endpackage : lm_sm_sequencer_pkg
`default_nettype wire

// File: rtl/lm_sm_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : lm_sm_sequencer_if
//  Description : Decoder-side instruction request, ID/RR enable and flush,
//                plus the micro-op output bundle of the LM/SM sequencer.
//                master : instruction decoder / ID-RR side
//                slave  : lm_sm_sequencer
//  Ports (signals)
//    in_valid, in_LM, in_SM, in_base, in_mask, in_PC, in_PC_plus : request
//    downstream_ready : ID/RR enable, flush : branch-redirect kill
//    in_ready, stall_fetch : sequencer status
//    uop_valid, uop_LM, uop_SM, uop_reg, uop_base, uop_offset, uop_last,
//    uop_PC, uop_PC_plus : registered micro-op
//  Revision    : 1.0  initial release
// ============================================================================
interface lm_sm_sequencer_if
  import lm_sm_sequencer_pkg::*;
#(
  parameter int DW = 16
) ();

  logic             in_valid;
  logic             in_LM;
  logic             in_SM;
  logic [REGW-1:0]  in_base;
  logic [MASKW-1:0] in_mask;
  logic [DW-1:0]    in_PC;
  logic [DW-1:0]    in_PC_plus;
  logic             downstream_ready;
  logic             flush;

  logic             in_ready;
  logic             stall_fetch;
  logic             uop_valid;
  logic             uop_LM;
  logic             uop_SM;
  logic [REGW-1:0]  uop_reg;
  logic [REGW-1:0]  uop_base;
  logic [DW-1:0]    uop_offset;
  logic             uop_last;
  logic [DW-1:0]    uop_PC;
  logic [DW-1:0]    uop_PC_plus;

  modport master (
    output in_valid, in_LM, in_SM, in_base, in_mask, in_PC, in_PC_plus,
    output downstream_ready, flush,
    input  in_ready, stall_fetch,
    input  uop_valid, uop_LM, uop_SM, uop_reg, uop_base, uop_offset,
    input  uop_last, uop_PC, uop_PC_plus
  );

  modport slave (
    input  in_valid, in_LM, in_SM, in_base, in_mask, in_PC, in_PC_plus,
    input  downstream_ready, flush,
    output in_ready, stall_fetch,
    output uop_valid, uop_LM, uop_SM, uop_reg, uop_base, uop_offset,
    output uop_last, uop_PC, uop_PC_plus
  );

endinterface : lm_sm_sequencer_if
`default_nettype wire

// File: rtl/lm_sm_sequencer_lowest_set_bit8.sv
`default_nettype none
// ============================================================================
//  Module      : lowest_set_bit8
//  Description : Combinational 8-bit priority encoder, lowest bit wins.
//  Ports
//    mask         in  8  candidate bits
//    index        out 3  position of the lowest set bit (0 when none)
//    found        out 1  at least one bit set
//    mask_cleared out 8  mask with the lowest set bit removed
//  Revision    : 1.0  initial release
// ============================================================================
module lowest_set_bit8
  import lm_sm_sequencer_pkg::*;
(
  input  wire logic [MASKW-1:0] mask,
  output logic      [REGW-1:0]  index,
  output logic                  found,
  output logic      [MASKW-1:0] mask_cleared
);

  always_comb begin
    index = '0;
    // Scan high to low so the lowest set bit is the last one written.
    for (int i = MASKW - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = REGW'(i);
      end
    end
  end

  assign found        = |mask;
  // x & (x-1) drops exactly the lowest set bit.
  assign mask_cleared = mask & (mask - MASKW'(1));

endmodule : lowest_set_bit8
`default_nettype wire

// File: rtl/lm_sm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lm_sm_sequencer
//  Description : Expands an LM/SM instruction into one micro-op per set mask
//                bit, lowest register first, feeding the ID/RR register.
//                Fetch/decode is stalled while further micro-ops remain.
//  Ports
//    clock  in  1  rising-edge clock
//    clear  in  1  asynchronous active-low reset
//    bus    slave modport of lm_sm_sequencer_if (request, ready, flush,
//           status and registered micro-op outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
#(
  parameter int DW = 16
) (
  input  wire logic           clock,
  input  wire logic           clear,
  lm_sm_sequencer_if.slave    bus
);

  state_t           r_state, w_nxt_state;
  logic [MASKW-1:0] r_remaining, w_nxt_remaining;

  logic             r_uop_valid,   w_nxt_uop_valid;
  logic             r_uop_lm,      w_nxt_uop_lm;
  logic             r_uop_sm,      w_nxt_uop_sm;
  logic [REGW-1:0]  r_uop_reg,     w_nxt_uop_reg;
  logic [REGW-1:0]  r_uop_base,    w_nxt_uop_base;
  logic [DW-1:0]    r_uop_offset,  w_nxt_uop_offset;
  logic             r_uop_last,    w_nxt_uop_last;
  logic [DW-1:0]    r_uop_pc,      w_nxt_uop_pc;
  logic [DW-1:0]    r_uop_pc_plus, w_nxt_uop_pc_plus;

  logic [MASKW-1:0] w_pe_in;
  logic [REGW-1:0]  w_pe_index;
  logic             w_pe_found;
  logic [MASKW-1:0] w_pe_cleared;
  logic             w_legal;

  // While idle the encoder looks at the incoming mask for the first
  // micro-op; during expansion it walks the remaining mask.
  assign w_pe_in = (r_state == ST_IDLE) ? bus.in_mask : r_remaining;

  lowest_set_bit8 u_pe (
    .mask         (w_pe_in),
    .index        (w_pe_index),
    .found        (w_pe_found),
    .mask_cleared (w_pe_cleared)
  );

  // Exactly one of LM/SM and a non-empty mask; anything else is consumed
  // without producing a micro-op.
  assign w_legal = (bus.in_LM ^ bus.in_SM) & w_pe_found;

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_remaining   = r_remaining;
    w_nxt_uop_valid   = r_uop_valid;
    w_nxt_uop_lm      = r_uop_lm;
    w_nxt_uop_sm      = r_uop_sm;
    w_nxt_uop_reg     = r_uop_reg;
    w_nxt_uop_base    = r_uop_base;
    w_nxt_uop_offset  = r_uop_offset;
    w_nxt_uop_last    = r_uop_last;
    w_nxt_uop_pc      = r_uop_pc;
    w_nxt_uop_pc_plus = r_uop_pc_plus;

    if (bus.flush) begin
      // Redirect beats both stalls and a simultaneous accept.
      w_nxt_state     = ST_IDLE;
      w_nxt_remaining = '0;
      w_nxt_uop_valid = 1'b0;
      w_nxt_uop_last  = 1'b0;
    end else if (bus.downstream_ready) begin
      case (r_state)
        ST_IDLE: begin
          w_nxt_uop_valid = 1'b0;
          if (bus.in_valid && w_legal) begin
            w_nxt_uop_valid   = 1'b1;
            w_nxt_uop_lm      = bus.in_LM;
            w_nxt_uop_sm      = bus.in_SM;
            w_nxt_uop_reg     = w_pe_index;
            w_nxt_uop_base    = bus.in_base;
            w_nxt_uop_offset  = '0;
            w_nxt_uop_pc      = bus.in_PC;
            w_nxt_uop_pc_plus = bus.in_PC_plus;
            w_nxt_remaining   = w_pe_cleared;
            w_nxt_uop_last    = (w_pe_cleared == '0);
            w_nxt_state       = (w_pe_cleared == '0) ? ST_IDLE : ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          w_nxt_uop_valid  = 1'b1;
          w_nxt_uop_reg    = w_pe_index;
          w_nxt_uop_offset = r_uop_offset + DW'(1);
          w_nxt_remaining  = w_pe_cleared;
          w_nxt_uop_last   = (w_pe_cleared == '0);
          w_nxt_state      = (w_pe_cleared == '0) ? ST_IDLE : ST_EXPAND;
        end
        default: begin
          w_nxt_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_remaining   <= '0;
      r_uop_valid   <= 1'b0;
      r_uop_lm      <= 1'b0;
      r_uop_sm      <= 1'b0;
      r_uop_reg     <= '0;
      r_uop_base    <= '0;
      r_uop_offset  <= '0;
      r_uop_last    <= 1'b0;
      r_uop_pc      <= '0;
      r_uop_pc_plus <= '0;
    end else begin
      r_remaining   <= w_nxt_remaining;
      r_uop_valid   <= w_nxt_uop_valid;
      r_uop_lm      <= w_nxt_uop_lm;
      r_uop_sm      <= w_nxt_uop_sm;
      r_uop_reg     <= w_nxt_uop_reg;
      r_uop_base    <= w_nxt_uop_base;
      r_uop_offset  <= w_nxt_uop_offset;
      r_uop_last    <= w_nxt_uop_last;
      r_uop_pc      <= w_nxt_uop_pc;
      r_uop_pc_plus <= w_nxt_uop_pc_plus;
    end
  end

  assign bus.in_ready    = (r_state == ST_IDLE);
  assign bus.stall_fetch = (r_state == ST_EXPAND);
  assign bus.uop_valid   = r_uop_valid;
  assign bus.uop_LM      = r_uop_lm;
  assign bus.uop_SM      = r_uop_sm;
  assign bus.uop_reg     = r_uop_reg;
  assign bus.uop_base    = r_uop_base;
  assign bus.uop_offset  = r_uop_offset;
  assign bus.uop_last    = r_uop_last;
  assign bus.uop_PC      = r_uop_pc;
  assign bus.uop_PC_plus = r_uop_pc_plus;

endmodule : lm_sm_sequencer
`default_nettype wire

// File: tb/tb_lm_sm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lm_sm_sequencer
//  Description : Self-checking bench for lm_sm_sequencer. Directed scenarios
//                plus randomized traffic compared against a queue-based
//                reference model of the micro-op stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lm_sm_sequencer;

  typedef struct packed {
    logic        lm;
    logic        sm;
    logic [2:0]  rg;
    logic [2:0]  base;
    logic [15:0] off;
    logic        last;
    logic [15:0] pc;
    logic [15:0] pcp;
  } uop_t;

  logic clock;
  logic clear;
  int   vectors;
  int   errors;

  // Reference model: micro-ops still to be issued, and what the output
  // register currently shows.
  uop_t pend[$];
  uop_t m_cur;
  logic m_valid;

  lm_sm_sequencer_if #(.DW(16)) bus ();

  lm_sm_sequencer #(.DW(16)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic model_clear();
    pend.delete();
    m_valid = 1'b0;
    m_cur   = '0;
  endtask

  // Advance the model with the inputs currently applied, then clock the DUT
  // and land 1 time unit after the rising edge.
  task automatic tick();
    uop_t u;
    int   k;
    if (bus.flush) begin
      pend.delete();
      m_valid    = 1'b0;
      m_cur.last = 1'b0;
    end else if (bus.downstream_ready) begin
      if (pend.size() != 0) begin
        m_cur   = pend.pop_front();
        m_valid = 1'b1;
      end else if (bus.in_valid && (bus.in_LM != bus.in_SM) && (bus.in_mask != 8'h00)) begin
        k = 0;
        for (int i = 0; i < 8; i++) begin
          if (bus.in_mask[i]) begin
            u.lm   = bus.in_LM;
            u.sm   = bus.in_SM;
            u.rg   = 3'(i);
            u.base = bus.in_base;
            u.off  = 16'(k);
            u.last = 1'b0;
            u.pc   = bus.in_PC;
            u.pcp  = bus.in_PC_plus;
            pend.push_back(u);
            k++;
          end
        end
        u = pend.pop_back();
        u.last = 1'b1;
        pend.push_back(u);
        m_cur   = pend.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic lm, input logic sm, input logic [2:0] base,
                         input logic [7:0] mask, input logic [15:0] pc);
    bus.in_valid   = 1'b1;
    bus.in_LM      = lm;
    bus.in_SM      = sm;
    bus.in_base    = base;
    bus.in_mask    = mask;
    bus.in_PC      = pc;
    bus.in_PC_plus = pc + 16'd1;
  endtask

  task automatic issue(input logic lm, input logic sm, input logic [2:0] base,
                       input logic [7:0] mask, input logic [15:0] pc);
    present(lm, sm, base, mask, pc);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_LM = 1'b0; bus.in_SM = 1'b0;
    bus.in_base = '0; bus.in_mask = '0; bus.in_PC = '0; bus.in_PC_plus = '0;
    bus.downstream_ready = 1'b1; bus.flush = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
    vectors++; if (bus.stall_fetch !== 1'b0) begin errors++; $display("FAIL reset stall_fetch: got %b want 0", bus.stall_fetch); end
    vectors++; if (bus.uop_valid !== 1'b0) begin errors++; $display("FAIL reset uop_valid: got %b want 0", bus.uop_valid); end
    vectors++; if (bus.uop_last !== 1'b0) begin errors++; $display("FAIL reset uop_last: got %b want 0", bus.uop_last); end
    vectors++; if ({bus.uop_reg, bus.uop_base, bus.uop_offset, bus.uop_PC, bus.uop_PC_plus} !== '0) begin
      errors++; $display("FAIL reset uop fields: got reg=%0d off=%0d pc=%h want all zero", bus.uop_reg, bus.uop_offset, bus.uop_PC);
    end
    #3 clear = 1'b1;
  endtask

  task automatic test_lm_a5();
    int regs[4] = '{0, 2, 5, 7};
    int stalls = 0;
    issue(1'b1, 1'b0, 3'd3, 8'b1010_0101, 16'h1234);
    for (int k = 0; k < 4; k++) begin
      vectors++; if (bus.uop_valid !== 1'b1 || bus.uop_LM !== 1'b1 || bus.uop_SM !== 1'b0) begin
        errors++; $display("FAIL lm_a5 type[%0d]: got v=%b lm=%b sm=%b want 1 1 0", k, bus.uop_valid, bus.uop_LM, bus.uop_SM);
      end
      vectors++; if (bus.uop_reg !== 3'(regs[k]) || bus.uop_offset !== 16'(k)) begin
        errors++; $display("FAIL lm_a5 reg/off[%0d]: got R%0d/%0d want R%0d/%0d", k, bus.uop_reg, bus.uop_offset, regs[k], k);
      end
      vectors++; if (bus.uop_last !== (k == 3) || bus.uop_base !== 3'd3 || bus.uop_PC !== 16'h1234 || bus.uop_PC_plus !== 16'h1235) begin
        errors++; $display("FAIL lm_a5 last/base/pc[%0d]: got %b/%0d/%h/%h want %b/3/1234/1235", k, bus.uop_last, bus.uop_base, bus.uop_PC, bus.uop_PC_plus, k == 3);
      end
      if (bus.stall_fetch === 1'b1) stalls++;
      if (k < 3) tick();
    end
    vectors++; if (stalls != 3) begin errors++; $display("FAIL lm_a5 stall cycles: got %0d want 3", stalls); end
    tick();
    vectors++; if (bus.uop_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL lm_a5 drain: got v=%b rdy=%b want 0 1", bus.uop_valid, bus.in_ready);
    end
  endtask

  task automatic test_single_sm();
    issue(1'b0, 1'b1, 3'd5, 8'b1000_0000, 16'h0040);
    vectors++; if (bus.uop_valid !== 1'b1 || bus.uop_SM !== 1'b1 || bus.uop_reg !== 3'd7 || bus.uop_offset !== 16'd0 || bus.uop_last !== 1'b1) begin
      errors++; $display("FAIL single_sm uop: got v=%b sm=%b R%0d off=%0d last=%b want 1 1 R7 0 1", bus.uop_valid, bus.uop_SM, bus.uop_reg, bus.uop_offset, bus.uop_last);
    end
    vectors++; if (bus.stall_fetch !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL single_sm status: got stall=%b rdy=%b want 0 1", bus.stall_fetch, bus.in_ready);
    end
  endtask

  task automatic test_stalls_ff();
    int k = 0;
    logic [2:0]  s_reg;
    logic [15:0] s_off;
    issue(1'b1, 1'b0, 3'd1, 8'hFF, 16'h0100);
    for (int c = 2; c < 20 && k < 7; c++) begin
      bus.downstream_ready = !(c == 2 || c == 5);
      s_reg = bus.uop_reg;
      s_off = bus.uop_offset;
      tick();
      if (!bus.downstream_ready) begin
        vectors++; if (bus.uop_reg !== s_reg || bus.uop_offset !== s_off || bus.uop_valid !== 1'b1 || bus.stall_fetch !== 1'b1) begin
          errors++; $display("FAIL stall_ff freeze c%0d: got R%0d/%0d v=%b st=%b want R%0d/%0d 1 1", c, bus.uop_reg, bus.uop_offset, bus.uop_valid, bus.stall_fetch, s_reg, s_off);
        end
      end else begin
        k++;
        vectors++; if (bus.uop_reg !== 3'(k) || bus.uop_offset !== 16'(k) || bus.uop_last !== (k == 7)) begin
          errors++; $display("FAIL stall_ff uop%0d: got R%0d/%0d last=%b want R%0d/%0d last=%b", k, bus.uop_reg, bus.uop_offset, bus.uop_last, k, k, k == 7);
        end
      end
    end
    bus.downstream_ready = 1'b1;
    vectors++; if (k != 7 || bus.stall_fetch !== 1'b0) begin
      errors++; $display("FAIL stall_ff count: got %0d uops stall=%b want 7 after first, 0", k, bus.stall_fetch);
    end
  endtask

  task automatic test_flush();
    issue(1'b1, 1'b0, 3'd2, 8'hFF, 16'h0200);
    tick();
    tick();
    vectors++; if (bus.uop_reg !== 3'd2 || bus.uop_valid !== 1'b1) begin
      errors++; $display("FAIL flush third uop: got R%0d v=%b want R2 1", bus.uop_reg, bus.uop_valid);
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    vectors++; if (bus.uop_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.stall_fetch !== 1'b0 || bus.uop_last !== 1'b0) begin
      errors++; $display("FAIL flush effect: got v=%b rdy=%b st=%b last=%b want 0 1 0 0", bus.uop_valid, bus.in_ready, bus.stall_fetch, bus.uop_last);
    end
    issue(1'b0, 1'b1, 3'd4, 8'h02, 16'h0300);
    vectors++; if (bus.uop_valid !== 1'b1 || bus.uop_reg !== 3'd1 || bus.uop_offset !== 16'd0 || bus.uop_last !== 1'b1 || bus.uop_SM !== 1'b1) begin
      errors++; $display("FAIL flush then sm: got v=%b R%0d off=%0d last=%b sm=%b want 1 R1 0 1 1", bus.uop_valid, bus.uop_reg, bus.uop_offset, bus.uop_last, bus.uop_SM);
    end
    // Flush coincident with an accept drops the instruction.
    present(1'b1, 1'b0, 3'd0, 8'h0F, 16'h0400);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    vectors++; if (bus.uop_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush with accept: got v=%b rdy=%b want 0 1", bus.uop_valid, bus.in_ready);
    end
  endtask

  task automatic test_illegal();
    issue(1'b0, 1'b1, 3'd1, 8'h10, 16'h0500);
    issue(1'b1, 1'b0, 3'd1, 8'h00, 16'h0510);
    vectors++; if (bus.uop_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL illegal mask0: got v=%b rdy=%b want 0 1", bus.uop_valid, bus.in_ready);
    end
    issue(1'b1, 1'b1, 3'd1, 8'hFF, 16'h0520);
    vectors++; if (bus.uop_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.stall_fetch !== 1'b0) begin
      errors++; $display("FAIL illegal both: got v=%b rdy=%b st=%b want 0 1 0", bus.uop_valid, bus.in_ready, bus.stall_fetch);
    end
    issue(1'b0, 1'b0, 3'd1, 8'hFF, 16'h0530);
    vectors++; if (bus.uop_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL illegal neither: got v=%b rdy=%b want 0 1", bus.uop_valid, bus.in_ready);
    end
  endtask

  task automatic test_async_clear();
    issue(1'b1, 1'b0, 3'd6, 8'hFF, 16'h0600);
    tick();
    #2 clear = 1'b0;
    #1;
    vectors++; if (bus.uop_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.stall_fetch !== 1'b0) begin
      errors++; $display("FAIL async clear status: got v=%b rdy=%b st=%b want 0 1 0", bus.uop_valid, bus.in_ready, bus.stall_fetch);
    end
    vectors++; if (bus.uop_reg !== 3'd0 || bus.uop_offset !== 16'd0 || bus.uop_PC !== 16'd0 || bus.uop_LM !== 1'b0) begin
      errors++; $display("FAIL async clear fields: got R%0d off=%0d pc=%h lm=%b want 0", bus.uop_reg, bus.uop_offset, bus.uop_PC, bus.uop_LM);
    end
    model_clear();
    clear = 1'b1;
    issue(1'b1, 1'b0, 3'd0, 8'h0C, 16'h0700);
    vectors++; if (bus.uop_reg !== 3'd2 || bus.uop_offset !== 16'd0 || bus.uop_last !== 1'b0) begin
      errors++; $display("FAIL post clear uop0: got R%0d off=%0d last=%b want R2 0 0", bus.uop_reg, bus.uop_offset, bus.uop_last);
    end
    tick();
    vectors++; if (bus.uop_reg !== 3'd3 || bus.uop_offset !== 16'd1 || bus.uop_last !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL post clear uop1: got R%0d off=%0d last=%b rdy=%b want R3 1 1 1", bus.uop_reg, bus.uop_offset, bus.uop_last, bus.in_ready);
    end
  endtask

  task automatic test_random();
    int t;
    for (int n = 0; n < 600; n++) begin
      t = $urandom_range(0, 7);
      bus.in_valid         = ($urandom_range(0, 1) == 1);
      bus.in_LM            = (t < 3) || (t == 6);
      bus.in_SM            = (t >= 3 && t < 6) || (t == 6);
      bus.in_base          = 3'($urandom);
      bus.in_mask          = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      bus.in_PC            = 16'($urandom);
      bus.in_PC_plus       = bus.in_PC + 16'd1;
      bus.downstream_ready = ($urandom_range(0, 4) != 0);
      bus.flush            = ($urandom_range(0, 24) == 0);
      tick();
      vectors++; if (bus.in_ready !== (pend.size() == 0) || bus.stall_fetch !== (pend.size() != 0)) begin
        errors++; $display("FAIL random status n%0d: got rdy=%b st=%b pending=%0d", n, bus.in_ready, bus.stall_fetch, pend.size());
      end
      vectors++; if (bus.uop_valid !== m_valid) begin
        errors++; $display("FAIL random valid n%0d: got %b want %b", n, bus.uop_valid, m_valid);
      end
      vectors++; if ({bus.uop_LM, bus.uop_SM, bus.uop_reg, bus.uop_base, bus.uop_offset, bus.uop_last, bus.uop_PC, bus.uop_PC_plus} !== m_cur) begin
        errors++; $display("FAIL random uop n%0d: got lm=%b sm=%b R%0d b%0d off=%0d last=%b pc=%h want lm=%b sm=%b R%0d b%0d off=%0d last=%b pc=%h",
          n, bus.uop_LM, bus.uop_SM, bus.uop_reg, bus.uop_base, bus.uop_offset, bus.uop_last, bus.uop_PC,
          m_cur.lm, m_cur.sm, m_cur.rg, m_cur.base, m_cur.off, m_cur.last, m_cur.pc);
      end
    end
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.downstream_ready = 1'b1;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_lm_a5();
    test_single_sm();
    test_stalls_ff();
    test_flush();
    test_illegal();
    test_async_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_lm_sm_sequencer
`default_nettype wire
